max_scan: RTL and testbench

MAX_SCAN -- requirements
Module: max_scan

---
 rtl/max_pkg.sv | 11 +
 rtl/max_scan_if.sv | 28 ++
 rtl/max_scan_greater.sv | 10 +
 rtl/max_scan.sv | 98 +++++++++
 tb/tb_max_scan.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/max_pkg.sv
// Shared defaults and FSM encoding for the max_scan block.
package max_pkg;
    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/max_scan_if.sv
// Scan request, data stream and result handshake for max_scan.
interface max_scan_if
    import max_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [CNT_W-1:0] out_idx;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_idx, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_idx, busy
    );
endinterface

// File: rtl/max_scan_greater.sv
// Unsigned strict greater-than comparator.
module greater #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_gt
);
    assign o_gt = i_a > i_b;
endmodule

// File: rtl/max_scan.sv
// Streams len words and reports the maximum and the index of its first occurrence.
module max_scan
    import max_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    max_scan_if.slave  bus
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_max;
    logic [CNT_W-1:0] r_idx;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic w_gt;
    logic w_acc;
    logic w_last;

    greater #(.WIDTH(WIDTH)) u_gt (
        .i_a  (bus.in_data),
        .i_b  (r_max),
        .o_gt (w_gt)
    );

    // r_in_ready is high exactly in SCAN, so it doubles as the state qualifier.
    assign w_acc  = r_in_ready & bus.in_valid;
    assign w_last = (r_cnt == (r_len - ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_max       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && (bus.len != '0)) begin
                        r_state    <= SCAN;
                        r_len      <= bus.len;
                        r_cnt      <= '0;
                        r_max      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                SCAN: begin
                    if (w_acc) begin
                        if ((r_cnt == '0) || w_gt) begin
                            r_max <= bus.in_data;
                            r_idx <= r_cnt;
                        end
                        // Counter parks at len-1 on the last beat so it never wraps.
                        if (w_last) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_max   = r_max;
    assign bus.out_idx   = r_idx;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_max_scan.sv
// Scoreboard bench for max_scan: expected results queued at stimulus, popped on handshake.
module tb_max_scan;
    import max_pkg::*;

    typedef struct {
        logic [3:0] mx;
        logic [3:0] ix;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_pop = 0;
    int   n_push = 0;
    exp_t sb[$];
    exp_t last;
    logic [3:0] vals [16];

    max_scan_if #(.WIDTH(4), .CNT_W(4)) bus ();

    max_scan #(.WIDTH(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_pop++;
                chk("out_max", {28'd0, bus.out_max}, {28'd0, e.mx});
                chk("out_idx", {28'd0, bus.out_idx}, {28'd0, e.ix});
            end
        end
    end

    task automatic send_scan(input int n, input int gap);
        exp_t e;
        e.mx = '0;
        e.ix = '0;
        for (int i = 0; i < n; i++) begin
            if (i == 0 || vals[i] > e.mx) begin
                e.mx = vals[i];
                e.ix = 4'(i);
            end
        end
        sb.push_back(e);
        n_push++;
        last = e;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len   = 4'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 4'hf;
                @(negedge clk);
                chk("gap_in_ready", {31'd0, bus.in_ready}, 1);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = vals[i];
            @(negedge clk);
            chk("beat_in_ready", {31'd0, bus.in_ready}, 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_out_valid", {31'd0, bus.out_valid}, 1);
        chk("done_in_ready", {31'd0, bus.in_ready}, 0);
        chk("done_busy", {31'd0, bus.busy}, 1);
    endtask

    task automatic finish_scan(input int hold, input bit pulse);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            bus.start     = pulse ? ~h[0] : 1'b0;
            bus.len       = 4'd3;
            @(negedge clk);
            chk("hold_out_valid", {31'd0, bus.out_valid}, 1);
            chk("hold_out_max", {28'd0, bus.out_max}, {28'd0, last.mx});
            chk("hold_out_idx", {28'd0, bus.out_idx}, {28'd0, last.ix});
        end
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("idle_out_valid", {31'd0, bus.out_valid}, 0);
        chk("idle_busy", {31'd0, bus.busy}, 0);
        chk("idle_in_ready", {31'd0, bus.in_ready}, 0);
        chk("idle_hold_max", {28'd0, bus.out_max}, {28'd0, last.mx});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        last.mx = '0;
        last.ix = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_out_max", {28'd0, bus.out_max}, 0);
        chk("rst_out_idx", {28'd0, bus.out_idx}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        vals[0] = 4'd3; vals[1] = 4'd9; vals[2] = 4'd2; vals[3] = 4'd7;
        send_scan(4, 0);
        finish_scan(0, 1'b0);

        vals[0] = 4'd5; vals[1] = 4'd5; vals[2] = 4'd5;
        send_scan(3, 2);
        finish_scan(0, 1'b0);

        for (int i = 0; i < 15; i++) vals[i] = 4'(i);
        send_scan(15, 0);
        finish_scan(0, 1'b0);

        vals[0] = 4'd15;
        for (int i = 1; i < 15; i++) vals[i] = 4'd0;
        send_scan(15, 0);
        finish_scan(5, 1'b1);

        // len==0 start must not leave IDLE
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len   = 4'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("len0_busy", {31'd0, bus.busy}, 0);
            chk("len0_in_ready", {31'd0, bus.in_ready}, 0);
            chk("len0_out_valid", {31'd0, bus.out_valid}, 0);
            @(posedge clk); #1;
        end
        chk("len0_hold_max", {28'd0, bus.out_max}, 4'd15);

        // reset in the middle of a scan, with every other input active
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len   = 4'd4;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd8;
        @(posedge clk); #1;
        bus.in_data  = 4'd3;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.start     = 1'b1;
        bus.len       = 4'd2;
        bus.in_data   = 4'd15;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 0);
        chk("abort_busy", {31'd0, bus.busy}, 0);
        chk("abort_out_valid", {31'd0, bus.out_valid}, 0);
        chk("abort_out_max", {28'd0, bus.out_max}, 0);
        chk("abort_out_idx", {28'd0, bus.out_idx}, 0);

        vals[0] = 4'd6;
        send_scan(1, 0);
        finish_scan(0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 15);
            for (int i = 0; i < n; i++) vals[i] = 4'($urandom_range(0, 15));
            send_scan(n, $urandom_range(0, 1));
            finish_scan($urandom_range(0, 2), 1'b0);
        end

        repeat (2) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("sb_pop_count", n_pop, n_push);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
